// File: rtl/prf_wr_arb_pkg.sv
// prf_wr_arb_pkg: shared types and rotate-priority helper for the PRF write arbiter
package prf_wr_arb_pkg;
  localparam int PRF_WR_ARB_MAX_REQ = 8;
  typedef enum logic [1:0] {PRF_INT, PRF_FP, PRF_VEC, PRF_FLAG} t_prf_type;
  typedef struct packed {
    t_prf_type   ptype;
    logic [5:0]  idx;
  } t_pdst;
  typedef struct packed {
    t_pdst       pdst;
    logic [31:0] data;
  } t_prf_wr_pkt;
  typedef logic [$clog2(PRF_WR_ARB_MAX_REQ)-1:0] t_prf_wr_req_id;
  typedef struct packed {
    logic           found;
    t_prf_wr_req_id idx;
  } t_ff1;
  function automatic t_ff1 find_first1(input logic [PRF_WR_ARB_MAX_REQ-1:0] v, input t_prf_wr_req_id ptr);
    logic [PRF_WR_ARB_MAX_REQ-1:0] m;
    m = v & ({PRF_WR_ARB_MAX_REQ{1'b1}} << ptr);
    find_first1 = '0;
    for (int i = PRF_WR_ARB_MAX_REQ - 1; i >= 0; i--)
      if (v[i]) find_first1 = '{found: 1'b1, idx: t_prf_wr_req_id'(i)};
    for (int i = PRF_WR_ARB_MAX_REQ - 1; i >= 0; i--)
      if (m[i]) find_first1 = '{found: 1'b1, idx: t_prf_wr_req_id'(i)};
  endfunction
endpackage

// File: rtl/prf_wr_arb_if.sv
// prf_wr_arb_if: requester handshake and PRF write-port bundle
interface prf_wr_arb_if import prf_wr_arb_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int NUM_REG_WRITES = 1
);
  logic [NUM_REQ-1:0]        req_valid_ex;
  logic [NUM_REQ-1:0]        req_ready_ex;
  t_prf_wr_pkt               req_pkt_ex [NUM_REQ];
  logic [NUM_REG_WRITES-1:0] wr_en_nq_ro0;
  t_prf_wr_pkt               wr_pkt_ro0 [NUM_REG_WRITES];
  modport master (output req_valid_ex, req_pkt_ex, input req_ready_ex, wr_en_nq_ro0, wr_pkt_ro0);
  modport slave (input req_valid_ex, req_pkt_ex, output req_ready_ex, wr_en_nq_ro0, wr_pkt_ro0);
endinterface

// File: rtl/prf_wr_fifo.sv
// prf_wr_fifo: per-requester writeback buffer with flush
module prf_wr_fifo import prf_wr_arb_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  t_prf_wr_pkt                pkt,
  output t_prf_wr_pkt                head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] rd_ptr, wr_ptr;
  t_prf_wr_pkt mem [DEPTH];
  assign head  = mem[rd_ptr];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  // pointer and occupancy state; flush drops everything buffered
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  // storage is not reset; the arbiter masks heads of empty FIFOs
  always_ff @(posedge clk)
    if (push && !flush) mem[wr_ptr] <= pkt;
  // occupancy invariants
  always_ff @(posedge clk)
    if (!reset) begin
      assert (!(push && full));
      assert (count <= CW'(DEPTH));
    end
endmodule

// File: rtl/prf_wr_arb.sv
// prf_wr_arb: round-robin scheduler of buffered writebacks onto the PRF write ports
module prf_wr_arb import prf_wr_arb_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int NUM_REG_WRITES = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  prf_wr_arb_if.slave   bus,
  output logic          arb_idle
);
  localparam int MAXR = PRF_WR_ARB_MAX_REQ;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [NUM_REQ-1:0] empty, full, push, grant;
  logic [CW-1:0]      count [NUM_REQ];
  t_prf_wr_pkt        head [NUM_REQ];
  logic [MAXR-1:0]    pend;
  t_prf_wr_req_id     rr_ptr, rr_nxt;
  t_ff1               ff;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign bus.req_ready_ex[i] = ~reset & ~full[i];
    assign push[i] = bus.req_valid_ex[i] & bus.req_ready_ex[i] & ~flush;
    prf_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(push[i]), .pop(grant[i]), .flush(flush),
      .pkt(bus.req_pkt_ex[i]), .head(head[i]), .count(count[i]), .empty(empty[i]), .full(full[i])
    );
  end
  // grant the first NUM_REG_WRITES non-empty FIFOs in rotating order; k-th grant drives port k
  always_comb begin
    pend = '0;
    pend[NUM_REQ-1:0] = ~empty;
    grant = '0;
    ff = '0;
    rr_nxt = rr_ptr;
    bus.wr_en_nq_ro0 = '0;
    for (int k = 0; k < NUM_REG_WRITES; k++) bus.wr_pkt_ro0[k] = '0;
    for (int k = 0; k < NUM_REG_WRITES; k++) begin
      ff = find_first1(pend, rr_ptr);
      if (ff.found && !flush) begin
        pend = pend & ~(MAXR'(1) << ff.idx);
        bus.wr_en_nq_ro0[k] = 1'b1;
        rr_nxt = ff.idx == t_prf_wr_req_id'(NUM_REQ - 1) ? '0 : ff.idx + 1'b1;
        for (int i = 0; i < NUM_REQ; i++)
          if (ff.idx == t_prf_wr_req_id'(i)) begin
            grant[i] = 1'b1;
            bus.wr_pkt_ro0[k] = head[i];
          end
      end
    end
  end
  // round-robin pointer advances past the last requester granted
  always_ff @(posedge clk or posedge reset)
    if (reset) rr_ptr <= '0;
    else rr_ptr <= flush ? '0 : rr_nxt;
  // idle when every FIFO count is zero
  always_comb begin
    arb_idle = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) arb_idle = count[i] != '0 ? 1'b0 : arb_idle;
  end
  // two live write ports must never target the same physical register
  always_ff @(posedge clk)
    if (!reset)
      for (int a = 0; a < NUM_REG_WRITES; a++)
        for (int b = a + 1; b < NUM_REG_WRITES; b++)
          assert (!(bus.wr_en_nq_ro0[a] && bus.wr_en_nq_ro0[b] && bus.wr_pkt_ro0[a].pdst == bus.wr_pkt_ro0[b].pdst));
endmodule

// File: tb/tb_prf_wr_arb.sv
// tb_prf_wr_arb: directed and randomized checks of prf_wr_arb with one and two write ports
module tb_prf_wr_arb;
  import prf_wr_arb_pkg::*;
  localparam int N = 3;
  localparam int D = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic idle0, idle1;
  logic [2:0] v [2];
  t_prf_wr_pkt p [3];
  logic idl [2];
  logic [2:0] rdy [2];
  logic [1:0] en [2];
  t_prf_wr_pkt wp [2][2];
  int checks = 0;
  int errors = 0;
  int seq = 0;
  t_prf_wr_pkt mq [6][$];
  int mrr [2];

  prf_wr_arb_if #(.NUM_REQ(3), .NUM_REG_WRITES(1)) b0 ();
  prf_wr_arb_if #(.NUM_REQ(3), .NUM_REG_WRITES(2)) b1 ();
  prf_wr_arb #(.NUM_REQ(3), .NUM_REG_WRITES(1), .FIFO_DEPTH(2)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush), .bus(b0), .arb_idle(idle0));
  prf_wr_arb #(.NUM_REQ(3), .NUM_REG_WRITES(2), .FIFO_DEPTH(2)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .bus(b1), .arb_idle(idle1));

  assign b0.req_valid_ex = v[0];
  assign b1.req_valid_ex = v[1];
  assign b0.req_pkt_ex = p;
  assign b1.req_pkt_ex = p;
  assign idl[0] = idle0;
  assign idl[1] = idle1;
  assign rdy[0] = b0.req_ready_ex;
  assign rdy[1] = b1.req_ready_ex;
  assign en[0] = {1'b0, b0.wr_en_nq_ro0};
  assign en[1] = b1.wr_en_nq_ro0;
  assign wp[0][0] = b0.wr_pkt_ro0[0];
  assign wp[0][1] = '0;
  assign wp[1][0] = b1.wr_pkt_ro0[0];
  assign wp[1][1] = b1.wr_pkt_ro0[1];

  always #5 clk = ~clk;

  // requester served on port k of dut d (port count d+1), or -1
  function automatic int gnt(int d, int k);
    int n = 0;
    if (k > d) return -1;
    for (int j = 0; j < N; j++) begin
      int r = (mrr[d] + j) % N;
      if (mq[d*N+r].size() != 0) begin
        if (n == k) return r;
        n++;
      end
    end
    return -1;
  endfunction

  function automatic t_prf_wr_pkt rand_pkt(int i);
    t_prf_wr_pkt x;
    x.pdst.ptype = t_prf_type'(2'($urandom_range(0, 3)));
    x.pdst.idx = 6'(seq);
    seq++;
    x.data = {8'(i), 24'($urandom)};
    return x;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2 * N; i++) mq[i].delete();
    mrr[0] = 0;
    mrr[1] = 0;
  endtask

  // advance the reference model by one edge, then move to the next falling edge
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      int g[$];
      bit acc[3];
      g.delete();
      for (int i = 0; i < N; i++) acc[i] = v[d][i] && mq[d*N+i].size() < D;
      for (int k = 0; k <= d; k++) if (gnt(d, k) >= 0) g.push_back(gnt(d, k));
      if (flush) begin
        for (int i = 0; i < N; i++) mq[d*N+i].delete();
        mrr[d] = 0;
      end else begin
        foreach (g[j]) void'(mq[d*N+g[j]].pop_front());
        if (g.size() != 0) mrr[d] = (g[g.size()-1] + 1) % N;
        for (int i = 0; i < N; i++) if (acc[i]) mq[d*N+i].push_back(p[i]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) p[i] = rand_pkt(i);
  endtask

  task automatic clean();
    flush = 1'b1;
    v[0] = '0;
    v[1] = '0;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (en[d] !== 2'b00 || wp[d][0] !== '0 || rdy[d] !== 3'b000 || idl[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold dut%0d: en=%b rdy=%b idle=%b pkt=%h, want en=0 rdy=000 idle=1 pkt=0", d, en[d], rdy[d], idl[d], wp[d][0]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (en[d] !== 2'b00 || rdy[d] !== 3'b111 || idl[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release dut%0d: en=%b rdy=%b idle=%b, want en=0 rdy=111 idle=1", d, en[d], rdy[d], idl[d]);
      end
    end
    v[0] = 3'b111;
    v[1] = 3'b111;
    tick();
    tick();
    v[0] = '0;
    v[1] = '0;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (en[d] !== 2'b00 || wp[d][0] !== '0 || rdy[d] !== 3'b000 || idl[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid dut%0d: en=%b rdy=%b idle=%b pkt=%h, want en=0 rdy=000 idle=1 pkt=0", d, en[d], rdy[d], idl[d], wp[d][0]);
      end
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (en[d] !== 2'b00 || rdy[d] !== 3'b111 || idl[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_release dut%0d: en=%b rdy=%b idle=%b, want en=0 rdy=111 idle=1", d, en[d], rdy[d], idl[d]);
      end
    end
  endtask

  task automatic test_fairness();
    v[0] = 3'b111;
    for (int c = 0; c < 7; c++) begin
      #1;
      checks++;
      if (c == 0 ? en[0] !== 2'b00 : (en[0] !== 2'b01 || wp[0][0].data[31:24] !== 8'((c - 1) % 3))) begin
        errors++;
        $display("FAIL fairness cycle %0d: en=%b src=%0d, want en=%0d src=%0d", c, en[0], wp[0][0].data[31:24], c != 0, c == 0 ? 0 : (c - 1) % 3);
      end
      tick();
    end
    v[0] = '0;
    clean();
  endtask

  task automatic test_single();
    clean();
    v[0] = 3'b010;
    p[1] = '{pdst: '{ptype: PRF_FP, idx: 6'd5}, data: 32'h1234};
    #1;
    checks++;
    if (en[0] !== 2'b00) begin
      errors++;
      $display("FAIL single_no_bypass: en=%b, want 0", en[0]);
    end
    tick();
    #1;
    checks++;
    if (en[0] !== 2'b01 || wp[0][0].pdst.idx !== 6'd5 || wp[0][0].pdst.ptype !== PRF_FP || wp[0][0].data !== 32'h1234) begin
      errors++;
      $display("FAIL single_write: en=%b pkt=%h, want en=1 ptype=1 idx=5 data=00001234", en[0], wp[0][0]);
    end
    v[0] = '0;
    tick();
    #1;
    checks++;
    if (en[0] !== 2'b00 || idl[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_drain: en=%b idle=%b, want en=0 idle=1", en[0], idl[0]);
    end
  endtask

  task automatic test_dual_port();
    clean();
    v[1] = 3'b001;
    tick();
    #1;
    checks++;
    if (en[1] !== 2'b01 || wp[1][0].data[31:24] !== 8'd0) begin
      errors++;
      $display("FAIL dual_first: en=%b src0=%0d, want en=01 src0=0", en[1], wp[1][0].data[31:24]);
    end
    v[1] = 3'b101;
    tick();
    #1;
    checks++;
    if (en[1] !== 2'b11 || wp[1][0].data[31:24] !== 8'd2 || wp[1][1].data[31:24] !== 8'd0) begin
      errors++;
      $display("FAIL dual_rotate: en=%b src0=%0d src1=%0d, want en=11 src0=2 src1=0", en[1], wp[1][0].data[31:24], wp[1][1].data[31:24]);
    end
    v[1] = 3'b011;
    tick();
    #1;
    checks++;
    if (en[1] !== 2'b11 || wp[1][0].data[31:24] !== 8'd1 || wp[1][1].data[31:24] !== 8'd0) begin
      errors++;
      $display("FAIL dual_rr_ptr: en=%b src0=%0d src1=%0d, want en=11 src0=1 src1=0", en[1], wp[1][0].data[31:24], wp[1][1].data[31:24]);
    end
    v[1] = '0;
    clean();
  endtask

  task automatic test_backpressure();
    logic [4:0] er;
    er = 5'b10111;
    clean();
    for (int c = 0; c < 5; c++) begin
      v[0] = c == 0 ? 3'b110 : 3'b111;
      #1;
      checks++;
      if (rdy[0][0] !== er[c]) begin
        errors++;
        $display("FAIL backpressure_ready cycle %0d: ready0=%b, want %b", c, rdy[0][0], er[c]);
      end
      if (c == 3) begin
        checks++;
        if (en[0] !== 2'b01 || wp[0][0].data[31:24] !== 8'd0) begin
          errors++;
          $display("FAIL backpressure_pop: en=%b src=%0d, want en=1 src=0", en[0], wp[0][0].data[31:24]);
        end
      end
      tick();
    end
    v[0] = '0;
    clean();
  endtask

  task automatic test_flush();
    clean();
    v[0] = 3'b111;
    tick();
    flush = 1'b1;
    v[0] = 3'b010;
    #1;
    checks++;
    if (en[0] !== 2'b00 || rdy[0] !== 3'b111 || idl[0] !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: en=%b rdy=%b idle=%b, want en=0 rdy=111 idle=0", en[0], rdy[0], idl[0]);
    end
    tick();
    flush = 1'b0;
    v[0] = '0;
    #1;
    checks++;
    if (en[0] !== 2'b00 || rdy[0] !== 3'b111 || idl[0] !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: en=%b rdy=%b idle=%b, want en=0 rdy=111 idle=1", en[0], rdy[0], idl[0]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      v[0] = 3'($urandom_range(0, 7));
      v[1] = 3'($urandom_range(0, 7));
      flush = $urandom_range(0, 15) == 0;
      #1;
      for (int d = 0; d < 2; d++) begin
        logic [2:0] er;
        logic ei;
        ei = 1'b1;
        for (int i = 0; i < N; i++) begin
          er[i] = mq[d*N+i].size() < D;
          if (mq[d*N+i].size() != 0) ei = 1'b0;
        end
        checks++;
        if (rdy[d] !== er || idl[d] !== ei) begin
          errors++;
          $display("FAIL random_status dut%0d cycle %0d: rdy=%b idle=%b, want rdy=%b idle=%b", d, c, rdy[d], idl[d], er, ei);
        end
        for (int k = 0; k <= d; k++) begin
          int r;
          logic ee;
          t_prf_wr_pkt ep;
          r = gnt(d, k);
          ee = !flush && r >= 0;
          ep = ee ? mq[d*N+r][0] : '0;
          checks++;
          if (en[d][k] !== ee || wp[d][k] !== ep) begin
            errors++;
            $display("FAIL random_port dut%0d port%0d cycle %0d: en=%b pkt=%h, want en=%b pkt=%h", d, k, c, en[d][k], wp[d][k], ee, ep);
          end
        end
      end
      tick();
    end
    flush = 1'b0;
    v[0] = '0;
    v[1] = '0;
  endtask

  initial begin
    v[0] = '0;
    v[1] = '0;
    for (int i = 0; i < N; i++) p[i] = rand_pkt(i);
    model_clear();
    test_reset();
    test_fairness();
    test_single();
    test_dual_port();
    test_backpressure();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prf_wr_arb.md
Name: prf_wr_arb

Overview:
- Write-port scheduler in front of the physical register file.
- Collects result-writeback requests from NUM_REQ execution sources (ALU, load, multiplier, ...), buffers them in per-source FIFOs and shares the NUM_REG_WRITES PRF write ports using round-robin arbitration.
- Drives the PRF's write-enable/write-packet port arrays directly, with no combinational path from requester inputs to write outputs.

Parameters:
- NUM_REQ, 3, number of writeback requesters (>=1)
- NUM_REG_WRITES, 1, number of PRF write ports (1..NUM_REQ)
- FIFO_DEPTH, 2, entries per requester FIFO (power of 2, >=1)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  pipeline flush; discards all buffered writes
- req_valid_ex  input  1 x [NUM_REQ]  requester has a write packet
- req_pkt_ex  input  $bits(t_prf_wr_pkt) x [NUM_REQ]  pdst (ptype, idx) plus data
- req_ready_ex  output  1 x [NUM_REQ]  requester FIFO can accept
- wr_en_nq_ro0  output  1 x [NUM_REG_WRITES]  PRF write enable per port
- wr_pkt_ro0  output  $bits(t_prf_wr_pkt) x [NUM_REG_WRITES]  PRF write packet per port
- arb_idle  output  1  all FIFOs empty

Behaviour:
- Reset (async assert, sync deassert at the edge): all FIFOs empty, counts 0, rr_ptr=0.
  - While reset is high: wr_en_nq_ro0=0, wr_pkt_ro0='0, req_ready_ex=0, arb_idle=1.
- Enqueue: when req_valid_ex[i] & req_ready_ex[i] at a rising edge, push req_pkt_ex[i] into FIFO i.
  - req_valid_ex without ready is ignored, with no error.
- req_ready_ex[i] = ~reset & (count[i] < FIFO_DEPTH).
  - Depends on registered count only; the same-cycle dequeue is not credited.
  - Consequence: a full FIFO accepts again one cycle after its dequeue.
- Latency: a packet enqueued at edge N is eligible for arbitration in the cycle after N. Earliest wr_en_nq_ro0 is that cycle. No bypass.
- Arbitration (combinational on registered FIFO state):
  - Scan requesters in order rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Grant the first NUM_REG_WRITES non-empty FIFOs.
  - The k-th grant in scan order drives port k: wr_en_nq_ro0[k]=1, wr_pkt_ro0[k]=FIFO head.
  - Unused ports: wr_en=0, pkt='0.
  - At most one grant per requester per cycle.
  - Granted FIFOs pop at the edge.
  - rr_ptr <= (last granted index + 1) mod NUM_REQ. If no grant, rr_ptr holds.
- Simultaneous push and pop on the same FIFO: both occur, count unchanged, pointers wrap modulo FIFO_DEPTH.
- Flush:
  - During the flush cycle: wr_en_nq_ro0 forced to 0 and all pushes ignored.
  - At the edge: all FIFOs emptied, rr_ptr=0.
  - req_ready_ex is unaffected by flush (it still reflects count).
- Type agnostic: ptype is passed through untouched. Each PRF instance filters its own type.
- arb_idle = all counts zero. Registered-derived; 1 during reset.
- Assertions (ASSERT builds):
  - No two asserted write ports carry the same pdst in one cycle.
  - No push to a full FIFO.
  - count never exceeds FIFO_DEPTH.
- Simulation builds: UINFO per grant giving requester, port and pdst.

Decomposition:
- rename_defs package: add t_prf_wr_req_id (clog2(NUM_REQ) bits) and PRF_WR_ARB_MAX_REQ = 8. t_prf_wr_pkt is reused unchanged.
- gen_funcs: add a rotate-priority find_first1 helper (mask by rr_ptr, fall back to unmasked).
- Sub-module prf_wr_fifo, one per requester:
  - Inputs: push, pop, flush, pkt.
  - Outputs: head, count, empty, full.
  - Own async-reset rd/wr pointers.
- Arbiter logic and rr_ptr live in prf_wr_arb.

Test Plan:
- Reset mid-traffic: 2 entries per FIFO, assert reset for 1 cycle → next cycle wr_en_nq_ro0=0, arb_idle=1, req_ready_ex all 1 after deassert, rr_ptr=0.
- Single request: NUM_REQ=3, W=1; req 1 pushes pdst idx 5, data 0x1234 at edge N → cycle N+1 wr_en_nq_ro0[0]=1, pkt idx 5 / 0x1234; cycle N+2 wr_en=0, arb_idle=1.
- Fairness: all 3 requesters continuously valid, W=1 → grant order 0,1,2,0,1,2; each requester gets exactly 1 write every 3 cycles; no FIFO overflow assertion.
- Dual port: W=2, FIFOs 0 and 2 non-empty, rr_ptr=1 → port0 = req 2, port1 = req 0; rr_ptr becomes 1.
- Backpressure: FIFO_DEPTH=2, W=1, req 0 valid every cycle while reqs 1 and 2 hog grants → req_ready_ex[0]=0 after 2 pushes; returns to 1 exactly one cycle after req 0's pop.
- Flush: 3 packets buffered, flush for 1 cycle with req_valid_ex[1]=1 → no write that cycle, the request is not enqueued, all FIFOs empty next cycle, arb_idle=1.
